// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared definitions for the pipelined CPU selector family.
//   DEF_WIDTH / DEF_N : default data width and source count
//   skid_state_t      : occupancy of the two-entry skid register
//   sel_width()       : select width for n sources, never less than 1
package mux_pipe_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_N     = 2;

    // Encoded so that bit 0 is OUT.valid and bit 1 is SKID.valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_t;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic two-entry skid register with valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_valid     : upstream word and offer
//   in_ready             : registered accept (low only when SKID is full)
//   out_data/out_valid   : OUT register contents
//   out_ready            : downstream accept
module pipe_skid_reg
    import mux_pipe_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    skid_state_t   state_reg, state_next;
    logic [DW-1:0] out_data_reg;
    logic [DW-1:0] skid_data_reg;
    logic          load_out;
    logic          load_skid;
    logic          skid_to_out;
    logic          accept;
    logic          drain;

    // Both handshake outputs decode straight from the state flops, so there
    // is no combinational path from out_ready to in_ready.
    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign out_data  = out_data_reg;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_next  = state_reg;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    load_out   = 1'b1;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = ST_FULL;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no new word can arrive.
                if (drain) begin
                    skid_to_out = 1'b1;
                    state_next  = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            out_data_reg  <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_out) begin
                out_data_reg <= in_data;
            end else if (skid_to_out) begin
                out_data_reg <= skid_data_reg;
            end
            if (load_skid) begin
                skid_data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// mux_pipe: registered N:1 selector with valid/ready and a two-entry skid.
//   in_data   : N flattened sources, source k at [k*WIDTH +: WIDTH]
//   sel       : source index sampled with in_valid
//   in_valid / in_ready   : upstream handshake (in_ready registered)
//   out_data / out_sel    : selected word and the index that produced it
//   out_valid / out_ready : downstream handshake
//   err_clr / sel_err     : sticky out-of-range-select flag and its clear
module mux_pipe
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               err_clr,
    output logic               sel_err
);

    logic [N-1:0]          hit;
    logic [WIDTH-1:0]      src_term [N];
    logic [WIDTH-1:0]      mux_data;
    logic                  sel_ok;
    logic                  accept;
    logic [WIDTH+SELW-1:0] word_out;
    logic                  sel_err_reg;

    // One-hot AND-OR select: an index with no matching source hits nothing,
    // which forces the data to zero and flags the select as out of range.
    for (genvar gi = 0; gi < N; gi++) begin : g_src
        assign hit[gi]      = (sel == SELW'(gi));
        assign src_term[gi] = hit[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) begin
            mux_data = mux_data | src_term[k];
        end
    end

    assign sel_ok = |hit;
    assign accept = in_valid && in_ready;

    pipe_skid_reg #(
        .DW(WIDTH + SELW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  ({mux_data, sel}),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (word_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_data = word_out[WIDTH+SELW-1:SELW];
    assign out_sel  = word_out[SELW-1:0];

    // Set has priority over clear so a bad select is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_reg <= 1'b0;
        end else if (accept && !sel_ok) begin
            sel_err_reg <= 1'b1;
        end else if (err_clr) begin
            sel_err_reg <= 1'b0;
        end
    end

    assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: three mux_pipe instances (N=2/W=5, N=4/W=8, N=3/W=4) checked
// with a vector table, hand sequences and a queue scoreboard.
module tb_mux_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: N=2, WIDTH=5
    logic [9:0] a_in_data;
    logic [0:0] a_sel;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err_clr, a_sel_err;
    logic [4:0] a_out_data;
    logic [0:0] a_out_sel;

    // Instance B: N=4, WIDTH=8
    logic [31:0] b_in_data;
    logic [1:0]  b_sel;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_clr, b_sel_err;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_sel;

    // Instance C: N=3, WIDTH=4
    logic [11:0] c_in_data;
    logic [1:0]  c_sel;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_err_clr, c_sel_err;
    logic [3:0]  c_out_data;
    logic [1:0]  c_out_sel;

    mux_pipe #(.WIDTH(5), .N(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .err_clr(a_err_clr), .sel_err(a_sel_err)
    );

    mux_pipe #(.WIDTH(8), .N(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .err_clr(b_err_clr), .sel_err(b_sel_err)
    );

    mux_pipe #(.WIDTH(4), .N(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .sel(c_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_sel(c_out_sel), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .err_clr(c_err_clr), .sel_err(c_sel_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard for instance B: {data[7:0], sel[1:0]}
    logic [9:0] sb_q[$];
    int n_push = 0;
    int n_pop  = 0;

    // Called at a falling edge; drives one cycle of B and returns at the next
    // falling edge. Handshakes are evaluated on the values that the following
    // rising edge will see.
    task automatic step_b(input logic v, input logic ordy, input bit quiet);
        logic [1:0]  s;
        logic [31:0] d;
        logic [9:0]  e;
        s = 2'($urandom_range(0, 3));
        d = $urandom;
        b_in_valid  = v;
        b_sel       = s;
        b_in_data   = d;
        b_out_ready = ordy;
        #1;
        n_vec++;
        if (!b_in_ready && !b_out_valid) begin
            n_err++;
            $display("FAIL skid_inv: in_ready=0 while out_valid=0 at %0t", $time);
        end
        if (b_out_valid && b_out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_pop: got out word %0h/%0h, expected none at %0t",
                         b_out_data, b_out_sel, $time);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                n_vec++;
                if ({b_out_data, b_out_sel} !== e) begin
                    n_err++;
                    $display("FAIL b_word: got %0h/%0h, expected %0h/%0h at %0t",
                             b_out_data, b_out_sel, e[9:2], e[1:0], $time);
                end else if (!quiet) begin
                    $display("ok   b_word: %0h/%0h", b_out_data, b_out_sel);
                end
            end
        end
        if (b_in_valid && b_in_ready) begin
            sb_q.push_back({d[int'(s)*8 +: 8], s});
            n_push++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic       v;
        logic       s;
        logic       ordy;
        logic       e_valid;
        logic [4:0] e_data;
        logic       e_sel;
        logic       e_ready;
    } vec_t;

    vec_t tbl[10];

    task automatic c_cycle(input logic v, input logic [1:0] s, input logic clr);
        c_in_valid = v;
        c_sel      = s;
        c_err_clr  = clr;
        @(negedge clk);
    endtask

    initial begin
        // sources: src0=13, src1=8
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd8,  1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd13, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1};

        a_in_data = {5'd8, 5'd13};
        a_sel = '0; a_in_valid = 0; a_out_ready = 0; a_err_clr = 0;
        b_in_data = '0; b_sel = '0; b_in_valid = 0; b_out_ready = 0; b_err_clr = 0;
        c_in_data = {4'hA, 4'h5, 4'h3};
        c_sel = '0; c_in_valid = 0; c_out_ready = 1; c_err_clr = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_ready", a_in_ready, 1);
        chk("rst_a_data",  a_out_data, 0);
        chk("rst_a_err",   a_sel_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: select, latency and back-pressure on the 2:1 instance
        for (int i = 0; i < 10; i++) begin
            a_in_valid  = tbl[i].v;
            a_sel       = tbl[i].s;
            a_out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("a_valid[%0d]", i), a_out_valid, tbl[i].e_valid);
            chk($sformatf("a_ready[%0d]", i), a_in_ready, tbl[i].e_ready);
            if (tbl[i].e_valid) begin
                chk($sformatf("a_data[%0d]", i), a_out_data, tbl[i].e_data);
                chk($sformatf("a_sel[%0d]", i), a_out_sel, tbl[i].e_sel);
            end
        end

        // Out-of-range select on the 3:1 instance
        c_cycle(1'b1, 2'd3, 1'b0);
        chk("c_bad_valid", c_out_valid, 1);
        chk("c_bad_data",  c_out_data, 0);
        chk("c_bad_sel",   c_out_sel, 3);
        chk("c_err_set",   c_sel_err, 1);
        c_cycle(1'b0, 2'd0, 1'b0);
        chk("c_err_sticky", c_sel_err, 1);
        c_cycle(1'b0, 2'd0, 1'b1);
        chk("c_err_clr", c_sel_err, 0);
        c_cycle(1'b1, 2'd2, 1'b0);
        chk("c_good_data", c_out_data, 4'hA);
        chk("c_good_sel",  c_out_sel, 2);
        chk("c_good_err",  c_sel_err, 0);
        c_cycle(1'b1, 2'd3, 1'b1);
        chk("c_set_wins", c_sel_err, 1);
        chk("c_set_data", c_out_data, 0);
        c_cycle(1'b0, 2'd0, 1'b0);
        chk("c_err_hold", c_sel_err, 1);

        // Streaming 100 words on the 4:1 instance
        n_pop = 0;
        for (int i = 0; i < 100; i++) begin
            step_b(1'b1, 1'b1, 1'b0);
            chk("b_stream_valid", b_out_valid, 1);
        end
        step_b(1'b0, 1'b1, 1'b0);
        chk("b_stream_count", n_pop, 100);
        chk("b_stream_empty", b_out_valid, 0);

        // Random handshake toggling with a mid-stream reset
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                step_b(1'b1, 1'b0, 1'b1);
                step_b(1'b1, 1'b0, 1'b1);
                b_in_valid = 1'b1;
                #2 rst_n = 1'b0;
                #1;
                chk("mid_rst_valid", b_out_valid, 0);
                chk("mid_rst_ready", b_in_ready, 1);
                chk("mid_rst_data",  b_out_data, 0);
                chk("mid_rst_sel",   b_out_sel, 0);
                chk("mid_rst_c_err", c_sel_err, 0);
                sb_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() != 0 || b_out_valid) step_b(1'b0, 1'b1, 1'b1);
        end
        chk("b_final_queue", sb_q.size(), 0);
        chk("b_final_valid", b_out_valid, 0);
        chk("b_final_ready", b_in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
# mux_pipe

Parametrised, registered N:1 selector with a valid/ready handshake and a two-entry skid buffer. It generalises the 5-bit 2:1 register-destination mux of the single-cycle CPU to N sources, any width, and a pipelined datapath that tolerates downstream back-pressure. It sits between decode and the write-back/forwarding logic of the pipelined CPU, selecting register indices or operands one cycle ahead of use. Out-of-range selects are trapped and reported.

## Interface
- WIDTH, 5, data width of each source and of the output
- N, 2, number of sources (N ≥ 2)
- SELW, $clog2(N) (minimum 1), select width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SELW  source index, sampled with in_valid
- in_valid  input  1  upstream offers a transfer
- in_ready  output  1  block can accept; registered
- out_data  output  WIDTH  selected data
- out_sel  output  SELW  index that produced out_data
- out_valid  output  1  out_data/out_sel valid
- out_ready  input  1  downstream accepts
- err_clr  input  1  clears sel_err
- sel_err  output  1  sticky: an out-of-range sel was accepted

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- Accepted word = {in_data[sel*WIDTH +: WIDTH], sel}; when sel ≥ N (only possible for non-power-of-2 N), data forced to 0 and sel_err set.
- Storage: output register (OUT) plus skid register (SKID), each with a valid bit.
- Input acceptance routing: OUT empty, or OUT draining this cycle with SKID empty → load OUT; otherwise → load SKID.
- OUT draining with SKID full → SKID moves to OUT the same edge; a simultaneous input accept is impossible (in_ready low).
- in_ready = !SKID.valid, registered (no combinational path from out_ready to in_ready).
- Order preserved; no word dropped or duplicated.
- sel_err: set on an accepted out-of-range sel; cleared by err_clr; set wins when both occur in the same cycle.
- States (from the valid bits): EMPTY (OUT 0, SKID 0), ONE (1, 0), FULL (1, 1). EMPTY→ONE on accept; ONE stays on accept+drain, →EMPTY on drain only, →FULL on accept without drain; FULL→ONE on drain. SKID.valid=1 with OUT.valid=0 is illegal.

## Timing
- Reset (async assert, sync deassert by clk domain): out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=1.
- Latency: accept at edge t → out_valid high after edge t, usable at edge t+1.
- Throughput: one word per cycle while out_ready is high.
- Back-pressure: out_ready low with OUT full → one more word absorbed into SKID, then in_ready drops the following cycle.
- out_data/out_sel stable while out_valid && !out_ready.
- Reset mid-operation: contents discarded immediately, outputs as above.

## Structure
- Shared package/header mux_pipe_pkg: default WIDTH, N, and the clog2 helper used for SELW (min 1); it is reused by the other CPU muxes.
- One sub-module, pipe_skid_reg: a generic (WIDTH+SELW)-bit two-entry skid register with the handshake. mux_pipe holds the select/range-check combinational front end and sel_err.

## Test plan
- Reset: hold rst_n=0 mid-stream with in_valid=1 → out_valid=0, in_ready=1, sel_err=0, out_data=0 asynchronously.
- N=2, WIDTH=5: sources {13, 8}; sel=1 then sel=0, out_ready=1 → out_data 8 then 13, each one cycle after accept, out_sel matches.
- N=4, streaming 100 words with random sel and out_ready=1 → one output per cycle, in order, matching a scoreboard.
- Back-pressure: out_ready=0 for 5 cycles while in_valid=1 → exactly two words held, in_ready low from the third cycle. Release → both words delivered in order with none lost.
- N=3: accept sel=3 → out_data=0, out_sel=3, sel_err=1 until err_clr. err_clr with a simultaneous bad sel → sel_err stays 1.
- Random out_ready and in_valid toggling, 10k cycles → no drop or duplicate, and SKID valid never set while OUT is empty.
